// File: rtl/hilo_pkg.sv
// Shared encodings for the Hi/Lo multiply/divide sequencer.
package hilo_pkg;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Command/result/read bus between decode, the sequencer and the Hi/Lo register.
// SIGNED_MULDIV_EN adds the sgn command bit.
interface hilo_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
`ifdef SIGNED_MULDIV_EN
  logic                 sgn;
`endif
  logic                 start;
  logic                 op;
  logic [WIDTH-1:0]     src_a;
  logic [WIDTH-1:0]     src_b;
  logic [WIDTH-1:0]     hi_in;
  logic [WIDTH-1:0]     lo_in;
  logic                 rd_req;
  logic                 rd_sel;
  logic                 busy;
  logic                 done;
  logic                 hilo_we;
  logic [2*WIDTH-1:0]   hilo_wdata;
  logic [WIDTH-1:0]     rd_data;
  logic                 stall;

  modport master (
`ifdef SIGNED_MULDIV_EN
    output sgn,
`endif
    output start, op, src_a, src_b, hi_in, lo_in, rd_req, rd_sel,
    input  busy, done, hilo_we, hilo_wdata, rd_data, stall
  );

  modport slave (
`ifdef SIGNED_MULDIV_EN
    input  sgn,
`endif
    input  start, op, src_a, src_b, hi_in, lo_in, rd_req, rd_sel,
    output busy, done, hilo_we, hilo_wdata, rd_data, stall
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
import hilo_pkg::*;

module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             op,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_nx,
  output logic [WIDTH-1:0] lo_nx
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shd;
  logic [WIDTH-1:0] diff;

  always_comb begin
    hi_nx = hi;
    lo_nx = lo;
    sum   = '0;
    shd   = '0;
    diff  = '0;
    if (op == OP_MULTU) begin
      // Carry of the add lands in sum[WIDTH] and is shifted straight into hi
      sum   = lo[0] ? ({1'b0, hi} + {1'b0, opnd}) : {1'b0, hi};
      hi_nx = sum[WIDTH:1];
      lo_nx = {sum[0], lo[WIDTH-1:1]};
    end else begin
      shd  = {hi, lo[WIDTH-1]};
      // Only used when shd >= opnd, so the true difference fits WIDTH bits
      diff = shd[WIDTH-1:0] - opnd;
      if (shd >= {1'b0, opnd}) begin
        hi_nx = diff;
        lo_nx = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = shd[WIDTH-1:0];
        lo_nx = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULTU/DIVU sequencer writing {Hi,Lo}; stalls MFHI/MFLO while busy.
// SIGNED_MULDIV_EN adds signed operation selected by bus.sgn.
import hilo_pkg::*;

module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  hilo_muldiv_ctrl_if.slave  bus
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               divz_q, divz_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;

  logic [WIDTH-1:0]   hi_nx, lo_nx;
  logic               neg_a_in, neg_b_in;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] result;

`ifdef SIGNED_MULDIV_EN
  assign neg_a_in = bus.sgn & bus.src_a[WIDTH-1];
  assign neg_b_in = bus.sgn & bus.src_b[WIDTH-1];
`else
  assign neg_a_in = 1'b0;
  assign neg_b_in = 1'b0;
`endif

  assign mag_a = neg_a_in ? (~bus.src_a + 1'b1) : bus.src_a;
  assign mag_b = neg_b_in ? (~bus.src_b + 1'b1) : bus.src_b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op    (op_q),
    .hi    (hi_q),
    .lo    (lo_q),
    .opnd  (opnd_q),
    .hi_nx (hi_nx),
    .lo_nx (lo_nx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    divz_d  = divz_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          op_d    = bus.op;
          neg_a_d = neg_a_in;
          neg_b_d = neg_b_in;
          hi_d    = '0;
          if (bus.op == OP_DIVU && bus.src_b == '0) begin
            // Divide by zero bypasses RUN and reports the raw dividend
            hi_d    = bus.src_a;
            lo_d    = '1;
            opnd_d  = '0;
            divz_d  = 1'b1;
            state_d = DONE;
          end else begin
            lo_d    = (bus.op == OP_MULTU) ? mag_b : mag_a;
            opnd_d  = (bus.op == OP_MULTU) ? mag_a : mag_b;
            divz_d  = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        hi_d  = hi_nx;
        lo_d  = lo_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      divz_q  <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      divz_q  <= divz_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
    end
  end

  // Sign fix-up happens on the DONE output path, so signed ops add no cycles
  always_comb begin
    result = {hi_q, lo_q};
    if (!divz_q) begin
      if (op_q == OP_MULTU) begin
        if (neg_a_q ^ neg_b_q) result = ~{hi_q, lo_q} + 1'b1;
      end else begin
        if (neg_a_q ^ neg_b_q) result[WIDTH-1:0]       = ~lo_q + 1'b1;
        if (neg_a_q)           result[2*WIDTH-1:WIDTH] = ~hi_q + 1'b1;
      end
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.hilo_we    = (state_q == DONE);
  assign bus.hilo_wdata = (state_q == DONE) ? result : '0;
  assign bus.stall      = bus.rd_req & (state_q != IDLE);
  assign bus.rd_data    = (bus.rd_sel == RD_HI) ? bus.hi_in : bus.lo_in;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl (define SIGNED_MULDIV_EN for signed cases).
module tb_hilo_muldiv_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  hilo_muldiv_ctrl_if #(.WIDTH(32)) bus ();

  hilo_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, wait (bounded) for done; lat counts edges from the start edge.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      tick();
      lat++;
    end
    res = bus.hilo_wdata;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hilo_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b done=%b we=%b required 0 0 0", bus.busy, bus.done, bus.hilo_we);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: got %b required 0", bus.stall);
    end
    checks++;
    if (bus.hilo_wdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_wdata: got %h required 0", bus.hilo_wdata);
    end
    checks++;
    if (bus.rd_data !== 32'hAAAA_0001) begin
      failures++;
      $display("FAIL reset_rd_hi: got %h required aaaa0001", bus.rd_data);
    end
    bus.rd_sel = 1'b0;
    #1;
    checks++;
    if (bus.rd_data !== 32'h5555_0002) begin
      failures++;
      $display("FAIL reset_rd_lo: got %h required 55550002", bus.rd_data);
    end
    bus.rd_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_multu();
    int          lat;
    logic [63:0] res;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
    checks++;
    if (lat !== 33) begin
      failures++;
      $display("FAIL mul_latency: got %0d required 33", lat);
    end
    checks++;
    if (res !== 64'hFFFF_FFFE_0000_0001 || bus.hilo_we !== 1'b1) begin
      failures++;
      $display("FAIL mul_max: got %h we=%b required fffffffe00000001 we=1", res, bus.hilo_we);
    end
    tick();
    checks++;
    if (bus.hilo_we !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL mul_pulse: we=%b done=%b required 0 0", bus.hilo_we, bus.done);
    end
    run_op(1'b0, 32'd3, 32'd5, lat, res);
    checks++;
    if (res !== 64'd15) begin
      failures++;
      $display("FAIL mul_small: got %h required f", res);
    end
    tick();
    run_op(1'b0, 32'h1234_5678, 32'h0000_0010, lat, res);
    checks++;
    if (res !== 64'h0000_0001_2345_6780) begin
      failures++;
      $display("FAIL mul_shift: got %h required 123456780", res);
    end
    tick();
  endtask

  task automatic test_divu();
    int          lat;
    logic [63:0] res;
    run_op(1'b1, 32'd100, 32'd7, lat, res);
    checks++;
    if (lat !== 33 || res !== {32'd2, 32'd14}) begin
      failures++;
      $display("FAIL div_100_7: got %h lat=%0d required 000000020000000e lat=33", res, lat);
    end
    tick();
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, lat, res);
    checks++;
    if (res !== {32'd0, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL div_by_one: got %h required 00000000ffffffff", res);
    end
    tick();
    run_op(1'b1, 32'd5, 32'd10, lat, res);
    checks++;
    if (res !== {32'd5, 32'd0}) begin
      failures++;
      $display("FAIL div_small: got %h required 0000000500000000", res);
    end
    tick();
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat, res);
    checks++;
    if (res !== {32'd1, 32'd1}) begin
      failures++;
      $display("FAIL div_large: got %h required 0000000100000001", res);
    end
    tick();
  endtask

  task automatic test_div_zero();
    int          lat;
    logic [63:0] res;
    run_op(1'b1, 32'd5, 32'd0, lat, res);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL divz_latency: got %0d required 1", lat);
    end
    checks++;
    if (res !== {32'd5, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL divz_result: got %h required 00000005ffffffff", res);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL divz_idle: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_stall();
    int   n;
    logic bad;
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b1;
    bus.start  = 1'b1;
    bus.op     = 1'b0;
    bus.src_a  = 32'd9;
    bus.src_b  = 32'd9;
    tick();
    bus.start = 1'b0;
    bad = 1'b0;
    n   = 1;
    while (!bus.done && n < 100) begin
      if (bus.stall !== 1'b1) bad = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (bad || bus.stall !== 1'b1 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL stall_busy: stall dropped=%b stall_at_done=%b done=%b required 0 1 1", bad, bus.stall, bus.done);
    end
    tick();
    checks++;
    if (bus.stall !== 1'b0 || bus.rd_data !== 32'hAAAA_0001) begin
      failures++;
      $display("FAIL stall_release: stall=%b rd=%h required 0 aaaa0001", bus.stall, bus.rd_data);
    end
    bus.rd_req = 1'b0;
  endtask

  task automatic test_restart_ignored();
    int          we_n;
    logic [63:0] res;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.src_a = 32'd6;
    bus.src_b = 32'd7;
    tick();
    bus.start = 1'b0;
    we_n = 0;
    res  = '0;
    for (int i = 0; i < 45; i++) begin
      if (i == 5) begin
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
      end
      if (i == 6) bus.start = 1'b0;
      if (bus.hilo_we) begin
        we_n++;
        res = bus.hilo_wdata;
      end
      tick();
    end
    checks++;
    if (we_n !== 1 || res !== 64'd42) begin
      failures++;
      $display("FAIL restart_ignored: we_count=%0d result=%h required 1 000000000000002a", we_n, res);
    end
  endtask

  task automatic test_reset_mid();
    int we_n;
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.hilo_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b we=%b required 0 0", bus.busy, bus.hilo_we);
    end
    tick();
    reset = 1'b0;
    we_n  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.hilo_we !== 1'b0) we_n++;
    end
    checks++;
    if (we_n !== 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_we: we_count=%0d busy=%b required 0 0", we_n, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [63:0] res;
    run_op(1'b0, 32'd11, 32'd13, lat, res);
    checks++;
    if (res !== 64'd143) begin
      failures++;
      $display("FAIL b2b_first: got %h required 8f", res);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: busy=%b required 0", bus.busy);
    end
    run_op(1'b1, 32'd1000, 32'd33, lat, res);
    checks++;
    if (lat !== 33 || res !== {32'd10, 32'd30}) begin
      failures++;
      $display("FAIL b2b_second: got %h lat=%0d required 0000000a0000001e lat=33", res, lat);
    end
    tick();
  endtask

`ifdef SIGNED_MULDIV_EN
  task automatic test_signed();
    int          lat;
    logic [63:0] res;
    bus.sgn = 1'b1;
    run_op(1'b0, 32'hFFFF_FFF9, 32'd3, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      failures++;
      $display("FAIL smul: got %h lat=%0d required ffffffffffffffeb lat=33", res, lat);
    end
    tick();
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, res);
    checks++;
    if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      failures++;
      $display("FAIL sdiv: got %h required fffffffffffffffd", res);
    end
    tick();
    run_op(1'b1, 32'hFFFF_FFF9, 32'd0, lat, res);
    checks++;
    if (lat !== 1 || res !== {32'hFFFF_FFF9, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL sdivz: got %h lat=%0d required fffffff9ffffffff lat=1", res, lat);
    end
    tick();
    bus.sgn = 1'b0;
  endtask
`endif

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 1'b0;
    bus.src_a  = '0;
    bus.src_b  = '0;
    bus.hi_in  = 32'hAAAA_0001;
    bus.lo_in  = 32'h5555_0002;
    bus.rd_req = 1'b0;
    bus.rd_sel = 1'b0;
`ifdef SIGNED_MULDIV_EN
    bus.sgn    = 1'b0;
`endif
    test_reset();
    test_multu();
    test_divu();
    test_div_zero();
    test_stall();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef SIGNED_MULDIV_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
